// File: rtl/stage2_pipe_reg_if.sv
// Decode-to-execute handshake bundle: stage-1 fields in, registered stage-2 fields out,
// plus the writeback bypass port, flush and stall controls.
interface stage2_pipe_reg_if #(
    parameter int unsigned CNT_W = 16
);
    logic             VALID_STAGE1;
    logic [6:0]       OPCODE_STAGE1;
    logic [4:0]       RADDR1_STAGE1;
    logic [4:0]       RADDR2_STAGE1;
    logic [4:0]       WR_ADDR_STAGE1;
    logic             WR_EN_STAGE1;
    logic [31:0]      RS1_DATA_STAGE1;
    logic [31:0]      RS2_DATA_STAGE1;
    logic [31:0]      IMM_STAGE1;
    logic [31:0]      PC_STAGE1;
    logic             WB_WR_EN;
    logic [4:0]       WB_ADDR;
    logic [31:0]      WB_DATA;
    logic             FLUSH;
    logic             STALL_IF;
    logic             VALID_STAGE2;
    logic             WR_EN_STAGE2;
    logic [6:0]       OPCODE_STAGE2;
    logic [4:0]       RADDR1_STAGE2;
    logic [4:0]       RADDR2_STAGE2;
    logic [4:0]       WR_ADDR_STAGE2;
    logic [31:0]      RS1_DATA_STAGE2;
    logic [31:0]      RS2_DATA_STAGE2;
    logic [31:0]      IMM_STAGE2;
    logic [31:0]      PC_STAGE2;
    logic [CNT_W-1:0] STALL_COUNT;

    modport master (
        output VALID_STAGE1, OPCODE_STAGE1, RADDR1_STAGE1, RADDR2_STAGE1, WR_ADDR_STAGE1,
               WR_EN_STAGE1, RS1_DATA_STAGE1, RS2_DATA_STAGE1, IMM_STAGE1, PC_STAGE1,
               WB_WR_EN, WB_ADDR, WB_DATA, FLUSH,
        input  STALL_IF, VALID_STAGE2, WR_EN_STAGE2, OPCODE_STAGE2, RADDR1_STAGE2,
               RADDR2_STAGE2, WR_ADDR_STAGE2, RS1_DATA_STAGE2, RS2_DATA_STAGE2, IMM_STAGE2,
               PC_STAGE2, STALL_COUNT
    );

    modport slave (
        input  VALID_STAGE1, OPCODE_STAGE1, RADDR1_STAGE1, RADDR2_STAGE1, WR_ADDR_STAGE1,
               WR_EN_STAGE1, RS1_DATA_STAGE1, RS2_DATA_STAGE1, IMM_STAGE1, PC_STAGE1,
               WB_WR_EN, WB_ADDR, WB_DATA, FLUSH,
        output STALL_IF, VALID_STAGE2, WR_EN_STAGE2, OPCODE_STAGE2, RADDR1_STAGE2,
               RADDR2_STAGE2, WR_ADDR_STAGE2, RS1_DATA_STAGE2, RS2_DATA_STAGE2, IMM_STAGE2,
               PC_STAGE2, STALL_COUNT
    );
endinterface

// File: rtl/stage2_pipe_reg.sv
// ID/EX pipeline register with load-use hazard stalling, writeback bypass on capture,
// flush handling and a saturating stall-cycle counter.
module stage2_pipe_reg #(
    parameter int unsigned LOAD_BUBBLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    stage2_pipe_reg_if.slave   bus
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    typedef struct packed {
        logic        valid;
        logic        wr_en;
        logic [6:0]  opcode;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [4:0]  wr_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } stage_t;

    state_e           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    stage_t           stage_q, stage_d, capture;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rs1_match, rs2_match, load_hazard, stall_if;

    always_comb begin
        rs1_match = (bus.RADDR1_STAGE1 == stage_q.wr_addr) &&
                    !(bus.OPCODE_STAGE1 inside {OpLui, OpAuipc, OpJal});
        rs2_match = (bus.RADDR2_STAGE1 == stage_q.wr_addr) &&
                    (bus.OPCODE_STAGE1 inside {OpReg, OpStore, OpBranch});
        load_hazard = stage_q.valid && (stage_q.opcode == OpLoad) && stage_q.wr_en &&
                      (stage_q.wr_addr != 5'd0) && bus.VALID_STAGE1 && (rs1_match || rs2_match);
    end

    // x0 always reads zero; otherwise a same-cycle writeback wins over the regfile read.
    always_comb begin
        capture.valid    = bus.VALID_STAGE1;
        capture.wr_en    = bus.WR_EN_STAGE1 & bus.VALID_STAGE1;
        capture.opcode   = bus.OPCODE_STAGE1;
        capture.raddr1   = bus.RADDR1_STAGE1;
        capture.raddr2   = bus.RADDR2_STAGE1;
        capture.wr_addr  = bus.WR_ADDR_STAGE1;
        capture.imm      = bus.IMM_STAGE1;
        capture.pc       = bus.PC_STAGE1;
        capture.rs1_data = bus.RS1_DATA_STAGE1;
        capture.rs2_data = bus.RS2_DATA_STAGE1;
        if (bus.RADDR1_STAGE1 == 5'd0) begin
            capture.rs1_data = '0;
        end else if (bus.WB_WR_EN && (bus.WB_ADDR == bus.RADDR1_STAGE1)) begin
            capture.rs1_data = bus.WB_DATA;
        end
        if (bus.RADDR2_STAGE1 == 5'd0) begin
            capture.rs2_data = '0;
        end else if (bus.WB_WR_EN && (bus.WB_ADDR == bus.RADDR2_STAGE1)) begin
            capture.rs2_data = bus.WB_DATA;
        end
    end

    // The hazard cycle itself is the first bubble; BCNT holds the bubbles still owed.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        stage_d  = capture;
        stall_if = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.FLUSH) begin
                    stage_d = '0;
                    bcnt_d  = 2'd0;
                end else if (load_hazard) begin
                    stall_if = 1'b1;
                    stage_d  = '0;
                    bcnt_d   = 2'(LOAD_BUBBLES - 1);
                    state_d  = (LOAD_BUBBLES > 1) ? StStall : StIdle;
                end
            end
            StStall: begin
                stage_d = '0;
                if (bus.FLUSH) begin
                    bcnt_d  = 2'd0;
                    state_d = StIdle;
                end else begin
                    stall_if = 1'b1;
                    bcnt_d   = bcnt_q - 2'd1;
                    if (bcnt_q <= 2'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                bcnt_d  = 2'd0;
            end
        endcase
        count_d = count_q;
        if (stall_if && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            bcnt_q  <= 2'd0;
            stage_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    assign bus.STALL_IF        = stall_if & reset_n;
    assign bus.VALID_STAGE2    = stage_q.valid;
    assign bus.WR_EN_STAGE2    = stage_q.wr_en;
    assign bus.OPCODE_STAGE2   = stage_q.opcode;
    assign bus.RADDR1_STAGE2   = stage_q.raddr1;
    assign bus.RADDR2_STAGE2   = stage_q.raddr2;
    assign bus.WR_ADDR_STAGE2  = stage_q.wr_addr;
    assign bus.RS1_DATA_STAGE2 = stage_q.rs1_data;
    assign bus.RS2_DATA_STAGE2 = stage_q.rs2_data;
    assign bus.IMM_STAGE2      = stage_q.imm;
    assign bus.PC_STAGE2       = stage_q.pc;
    assign bus.STALL_COUNT     = count_q;
endmodule

// File: doc/stage2_pipe_reg.md
STAGE2_PIPE_REG -- requirements
Module: stage2_pipe_reg

Interface
REQ-001 Parameter: LOAD_BUBBLES, default 2, number of bubbles inserted per load-use hazard (legal 1..3).
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 Clocking: one clock (clk); reset is synchronous and active-low (reset_n). All state updates on the clk rising edge.
REQ-004 clk  in  1  clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 VALID_STAGE1  in  1  decode slot holds a real instruction.
REQ-007 OPCODE_STAGE1  in  7  decoded opcode.
REQ-008 RADDR1_STAGE1, RADDR2_STAGE1, WR_ADDR_STAGE1  in  5 each  rs1/rs2/rd.
REQ-009 WR_EN_STAGE1  in  1  instruction writes rd.
REQ-010 RS1_DATA_STAGE1, RS2_DATA_STAGE1, IMM_STAGE1, PC_STAGE1  in  32 each  regfile reads, immediate, PC.
REQ-011 WB_WR_EN  in  1; WB_ADDR  in  5; WB_DATA  in  32  same-cycle writeback port.
REQ-012 FLUSH  in  1  taken branch/jump resolved downstream.
REQ-013 STALL_IF  out  1  freeze PC and IF/ID register this cycle.
REQ-014 VALID_STAGE2, WR_EN_STAGE2  out  1 each.
REQ-015 OPCODE_STAGE2  out  7.
REQ-016 RADDR1_STAGE2, RADDR2_STAGE2, WR_ADDR_STAGE2  out  5 each.
REQ-017 RS1_DATA_STAGE2, RS2_DATA_STAGE2, IMM_STAGE2, PC_STAGE2  out  32 each  operands consumed by the forwarding unit and ALU.
REQ-018 STALL_COUNT  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 Registered outputs: all *_STAGE2 outputs and STALL_COUNT. STALL_IF is combinational from state plus stage-1 inputs.
REQ-020 Load hazard detection: load hazard = VALID_STAGE2 & OPCODE_STAGE2==7'b0000011 & WR_EN_STAGE2 & WR_ADDR_STAGE2!=0 & VALID_STAGE1 & (rs1 match | rs2 match).
REQ-021 rs1 match: RADDR1_STAGE1==WR_ADDR_STAGE2, except when OPCODE_STAGE1 is 0110111, 0010111 or 1101111.
REQ-022 rs2 match: RADDR2_STAGE1==WR_ADDR_STAGE2, only when OPCODE_STAGE1 is 0110011, 0100011 or 1100011.
REQ-023 FSM states: IDLE, STALL (bubble counter BCNT, 2 bits).
REQ-024 IDLE transition: on load hazard & !FLUSH -> STALL, BCNT=LOAD_BUBBLES-1, STALL_IF=1, stage 2 loads a bubble.
REQ-025 STALL state: STALL_IF=1 and a bubble is loaded each cycle; BCNT decrements. When BCNT==0 the STALL_IF of that cycle is still 1, then -> IDLE.
REQ-026 Stall length: a hazard yields exactly LOAD_BUBBLES consecutive STALL_IF=1 cycles and bubbles.
REQ-027 Bubble contents: VALID=0, WR_EN=0, OPCODE=0, all address and data fields 0.
REQ-028 Normal capture: in IDLE with no hazard and no FLUSH, stage 2 captures all stage-1 fields, with VALID_STAGE2=VALID_STAGE1 and WR_EN_STAGE2=WR_EN_STAGE1&VALID_STAGE1.
REQ-029 Writeback bypass on capture: if WB_WR_EN & WB_ADDR!=0 & WB_ADDR==RADDR1_STAGE1, RS1_DATA_STAGE2 takes WB_DATA; RS2 is handled the same way.
REQ-030 Register x0 reads: reads of address 0 always capture 0.
REQ-031 FLUSH priority: FLUSH=1 overrides everything. Stage 2 loads a bubble, the FSM goes to IDLE, STALL_IF=0.
REQ-032 FLUSH during STALL: a FLUSH in any STALL cycle aborts the remaining bubbles.
REQ-033 STALL_COUNT: increments by 1 each cycle STALL_IF=1 and holds at all-ones.
REQ-034 Simultaneous hazard and WB write to the same register: the stall is still taken; the bypass applies on the eventual capture.

Reset
REQ-035 Reset action: reset_n=0 at a clk edge forces IDLE, BCNT=0, STALL_COUNT=0, and the stage-2 register to the bubble value.
REQ-036 Reset dominance: reset_n=0 overrides FLUSH and any in-progress stall.
REQ-037 STALL_IF during reset: STALL_IF=0 while reset_n=0.
REQ-038 First cycle after release: normal capture.

Verification
REQ-039 Scenario, back-to-back ALU ops: ADD x5 then ADD x6,x5,x1 -> no stall; in cycle 2, RADDR1_STAGE2=5, WR_ADDR_STAGE2=6, VALID_STAGE2=1.
REQ-040 Scenario, load-use: LW x5 in stage 2 and ADD x6,x5,x1 in stage 1 -> STALL_IF=1 for 2 cycles; 2 bubbles with OPCODE_STAGE2=0; ADD captured in cycle 3; STALL_COUNT=2.
REQ-041 Scenario, false hazards: LW x5, then LUI x5, then SW rs2=x5 after an ADDI with rs2 field 5 -> LUI and ADDI do not stall; SW stalls.
REQ-042 Scenario, bypass: WB_WR_EN=1, WB_ADDR=7, WB_DATA=0xDEADBEEF, RADDR2_STAGE1=7, RS2_DATA_STAGE1=0x1 -> RS2_DATA_STAGE2=0xDEADBEEF; with WB_ADDR=0 -> 0x1.
REQ-043 Scenario, flush aborts stall: FLUSH=1 in the first stall cycle -> bubble, STALL_IF=0 in that cycle, IDLE next, STALL_COUNT=0.
REQ-044 Scenario, reset and saturation: reset_n=0 mid-stall -> IDLE, all outputs 0 next edge; with CNT_W=2, 5 stall cycles -> STALL_COUNT=3.
